triggered_stream_gate: RTL and testbench

- Downstream consumer of the GPIO delayed-trigger stage. It takes that stage's `trigger` output, which is a level that stays high until the stage is reset.
- On the trigger's rising edge it opens an AXI4-Stream gate. It passes exactly a programmed number of ADC samples to the downstream writer/DMA, asserting TLAST on the final beat, then closes.
- Outside the capture window it drains the input stream so the upstream ADC path never stalls.
- Re-armed by software through a one-cycle `arm` pulse.

---
 rtl/triggered_stream_gate.sv | 122 ++++++++++++
 tb/tb_triggered_stream_gate.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triggered_stream_gate.sv
// triggered_stream_gate: AXI4-Stream capture gate opened by the rising edge
// of a level trigger. After a software arm pulse it passes exactly the
// programmed number of beats downstream, flags the final one with TLAST and
// then closes. Outside the capture window the input is drained so the
// upstream sample path never stalls.
module triggered_stream_gate #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        arm,
    input  logic [CNTR_WIDTH-1:0]       cfg_samples,
    input  logic                        trigger,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        armed,
    output logic                        busy,
    output logic                        done,
    output logic [CNTR_WIDTH-1:0]       sample_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [CNTR_WIDTH-1:0]   counter;
    logic [CNTR_WIDTH-1:0]   len_reg;
    logic                    trig_q;

    logic                    start_edge;
    logic                    beat;
    logic                    at_last;

    // A trigger that is already high when arm arrives produces no edge here,
    // so it cannot start a capture until it falls and rises again.
    assign start_edge = trigger & ~trig_q;
    assign beat       = (state == ST_RUN) & s_axis_tvalid & m_axis_tready;
    assign at_last    = (counter == (len_reg - CNTR_WIDTH'(1)));

    // Trigger history, capture length, beat counter and control state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            counter <= '0;
            len_reg <= '0;
            trig_q  <= 1'b0;
        end else begin
            trig_q <= trigger;
            case (state)
                ST_IDLE: begin
                    // Trigger edges are ignored here, even alongside arm.
                    if (arm) begin
                        state   <= ST_ARMED;
                        len_reg <= cfg_samples;
                        counter <= '0;
                    end
                end
                ST_ARMED: begin
                    if (start_edge) begin
                        counter <= '0;
                        if (len_reg == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (arm) begin
                        len_reg <= cfg_samples;
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        counter <= counter + CNTR_WIDTH'(1);
                        if (at_last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state   <= ST_ARMED;
                        len_reg <= cfg_samples;
                        counter <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stream routing: zero-latency passthrough in RUN, drain everywhere else.
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (state == ST_RUN) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tvalid & at_last;
        end
    end

    assign m_axis_tdata = s_axis_tdata;

    // Status flags decode straight from the state register.
    assign armed        = (state == ST_ARMED);
    assign busy         = (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign sample_count = counter;

endmodule

// File: tb/tb_triggered_stream_gate.sv
// Self-checking bench for triggered_stream_gate: expected output beats are
// queued when a capture is launched and popped by a monitor on each
// downstream handshake.
module tb_triggered_stream_gate;

    logic        aclk = 1'b0;
    logic        areset;
    logic        arm;
    logic [31:0] cfg_samples;
    logic        trigger;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        armed;
    logic        busy;
    logic        done;
    logic [31:0] sample_count;

    int checks = 0;
    int errors = 0;
    int out_beats = 0;
    logic [32:0] exp_q[$];

    triggered_stream_gate #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH(32)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .arm(arm),
        .cfg_samples(cfg_samples),
        .trigger(trigger),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .armed(armed),
        .busy(busy),
        .done(done),
        .sample_count(sample_count)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scores every downstream handshake against the expected queue.
    task automatic monitor();
        logic [32:0] exp;
        forever begin
            @(negedge aclk);
            if (m_tvalid !== 1'b1) begin
                checks++;
                if (m_tlast !== 1'b0) begin
                    errors++;
                    $display("FAIL tlast_without_valid got %b exp 0", m_tlast);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got data %h last %b exp no beat", m_tdata, m_tlast);
                end else begin
                    exp = exp_q.pop_front();
                    out_beats++;
                    if ({m_tlast, m_tdata} !== exp) begin
                        errors++;
                        $display("FAIL beat got last %b data %h exp last %b data %h",
                                 m_tlast, m_tdata, exp[32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic do_arm(input logic [31:0] n);
        arm = 1'b1;
        cfg_samples = n;
        tick();
        arm = 1'b0;
        cfg_samples = $urandom;
        checks++;
        if ({armed, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL arm_status got %b exp 100", {armed, busy, done});
        end
    endtask

    // Expects ARMED; makes a fresh trigger edge, then streams numbered beats.
    // abort_at > 0 stops feeding after that many accepted beats.
    task automatic run_capture(input int n, input bit rnd, input logic [31:0] base,
                               input int abort_at);
        int idx;
        int cyc;
        bit hs;
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({(k == n - 1), base + 32'(k)});
        end
        idx = 0;
        cyc = 0;
        s_tvalid = 1'b1;
        s_tdata = base;
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (idx < n && cyc < 2000) begin
            if (abort_at > 0 && idx == abort_at) break;
            @(negedge aclk);
            hs = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (hs) idx++;
            s_tdata = base + 32'(idx);
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL capture_timeout got %0d beats exp %0d", idx, n);
        end
    endtask

    task automatic check_done(input logic [31:0] n, input string name);
        checks++;
        if ({armed, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL %s_status got %b exp 001", name, {armed, busy, done});
        end
        checks++;
        if (sample_count !== n) begin
            errors++;
            $display("FAIL %s_count got %0d exp %0d", name, sample_count, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got %0d beats left exp 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        checks++;
        if ({armed, busy, done, m_tvalid, m_tlast, s_tready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000001",
                     {armed, busy, done, m_tvalid, m_tlast, s_tready});
        end
        checks++;
        if (sample_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", sample_count);
        end
    endtask

    task automatic test_basic();
        do_arm(32'd4);
        run_capture(4, 1'b0, 32'h0000_0100, 0);
        check_done(32'd4, "basic");
    endtask

    task automatic test_backpressure();
        do_arm(32'd8);
        run_capture(8, 1'b1, 32'h0000_0200, 0);
        check_done(32'd8, "backpressure");
    endtask

    task automatic test_rearm_done();
        do_arm(32'd2);
        checks++;
        if (sample_count !== 32'd0) begin
            errors++;
            $display("FAIL rearm_clear got %0d exp 0", sample_count);
        end
        run_capture(2, 1'b0, 32'h0000_0300, 0);
        check_done(32'd2, "rearm");
    endtask

    task automatic test_trigger_high();
        trigger = 1'b1;
        tick();
        do_arm(32'd3);
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 32'hdead_0000 + 32'(i);
            tick();
            checks++;
            if ({armed, busy, s_tready} !== 3'b101) begin
                errors++;
                $display("FAIL trig_high_hold got %b exp 101", {armed, busy, s_tready});
            end
        end
        s_tvalid = 1'b0;
        run_capture(3, 1'b0, 32'h0000_0400, 0);
        check_done(32'd3, "trig_high");
    endtask

    task automatic test_same_cycle();
        areset = 1'b1;
        trigger = 1'b0;
        tick();
        areset = 1'b0;
        trigger = 1'b1;
        tick();
        checks++;
        if ({armed, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_edge got %b exp 000", {armed, busy, done});
        end
        trigger = 1'b0;
        tick();
        arm = 1'b1;
        cfg_samples = 32'd5;
        trigger = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        checks++;
        if ({armed, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL same_cycle_status got %b exp 100", {armed, busy, done});
        end
        do_arm(32'd0);
        trigger = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 32'hbad0_0001;
        tick();
        trigger = 1'b1;
        tick();
        tick();
        tick();
        s_tvalid = 1'b0;
        check_done(32'd0, "zero_len");
    endtask

    task automatic test_reset_mid();
        do_arm(32'd10);
        run_capture(10, 1'b0, 32'h0000_0500, 3);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        checks++;
        if ({armed, busy, done, m_tvalid, m_tlast, s_tready} !== 6'b000001) begin
            errors++;
            $display("FAIL abort_outputs got %b exp 000001",
                     {armed, busy, done, m_tvalid, m_tlast, s_tready});
        end
        checks++;
        if (sample_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_count got %0d exp 0", sample_count);
        end
        checks++;
        if (exp_q.size() != 7) begin
            errors++;
            $display("FAIL abort_beats got %0d left exp 7", exp_q.size());
        end
        exp_q.delete();
        do_arm(32'd10);
        run_capture(10, 1'b0, 32'h0000_0600, 0);
        check_done(32'd10, "after_abort");
    endtask

    initial begin
        areset = 1'b1;
        arm = 1'b0;
        cfg_samples = '0;
        trigger = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_rearm_done();
        test_trigger_high();
        test_same_cycle();
        test_reset_mid();
        tick();
        tick();
        checks++;
        if (out_beats != 4 + 8 + 2 + 3 + 3 + 10) begin
            errors++;
            $display("FAIL total_beats got %0d exp 30", out_beats);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
